// File: rtl/seq_divider_ctrl.sv
// seq_divider_ctrl: restoring sequential divider, one quotient bit per cycle.
// Define DIV_ZERO_ERR_EN to get err_o and a single-cycle divide-by-zero exit.
module seq_divider_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
`ifdef DIV_ZERO_ERR_EN
  ,
  output logic             err_o
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt_q;
  logic             fin_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
`ifdef DIV_ZERO_ERR_EN
  logic             err_q;
`endif

  logic [WIDTH:0]   shift_w;
  logic [WIDTH+1:0] trial_w;
  logic             carry_w;
  logic             accept_w;
  logic             dz_w;

  // Shift in the next dividend bit and trial-subtract via A + ~B + 1.
  always_comb begin
    shift_w = {rem_q, dvd_q[cnt_q]};
    trial_w = {1'b0, shift_w}
            + {1'b0, ~{1'b0, dvs_q}}
            + {{(WIDTH + 1){1'b0}}, 1'b1};
    carry_w = trial_w[WIDTH+1];
  end

  assign accept_w = start_i &&
                    ((state_q == IDLE) || (state_q == DONE));

`ifdef DIV_ZERO_ERR_EN
  assign dz_w = (divisor_i == '0);
`else
  assign dz_w = 1'b0;
`endif

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      fin_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_ZERO_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
`ifdef DIV_ZERO_ERR_EN
      err_q <= 1'b0;
`endif
      if (accept_w) begin
        dvd_q <= dividend_i;
        dvs_q <= divisor_i;
        rem_q <= '0;
        quo_q <= '0;
        cnt_q <= CW'(WIDTH - 1);
        fin_q <= 1'b0;
        if (dz_w) begin
          // Zero divisor short-cuts straight to a flagged result.
          state_q     <= DONE;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          quotient_q  <= '0;
          remainder_q <= dividend_i;
`ifdef DIV_ZERO_ERR_EN
          err_q       <= 1'b1;
`endif
        end else begin
          state_q <= SUB;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
      end else begin
        unique case (state_q)
          SUB: begin
            if (fin_q) begin
              // All bits resolved: publish the result.
              state_q     <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              quotient_q  <= quo_q;
              remainder_q <= rem_q;
            end else begin
              rem_q <= carry_w ? trial_w[WIDTH-1:0]
                               : shift_w[WIDTH-1:0];
              quo_q[cnt_q] <= carry_w;
              if (cnt_q == '0) begin
                fin_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q - 1'b1;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
`ifdef DIV_ZERO_ERR_EN
  assign err_o       = err_q;
`endif

endmodule
